// File: rtl/bcd_step_counter.sv
// rtl/bcd_step_counter.sv - up/down modulo counter with step/load buttons and iterative BCD readout
//
// Purpose: WIDTH-bit counter over 0..MAX_COUNT, stepped by a synchronised,
// edge-detected pushbutton and parallel-loaded (saturating) from d. Every
// count change is converted to DIGITS BCD digits by a shift-add-3 engine
// that handles one bit per clock.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   step_n     step pushbutton, active-low, asynchronous to clk
//   load_n     load pushbutton, active-low, asynchronous to clk
//   en         step enable
//   dir        count direction, 1 = up, 0 = down
//   d          load value, saturated to MAX_COUNT
//   count      current count
//   tc         one-cycle pulse on wrap-around
//   bcd        last completed conversion, digit 0 in bits [3:0]
//   bcd_valid  one-cycle pulse when bcd is updated
//   busy       conversion in progress
//
// Optional feature macro: STEP_REPEAT_EN (auto-repeat while step_n is held).

module bcd_step_counter #(
  parameter int WIDTH         = 8,
  parameter int MAX_COUNT     = 255,
  parameter int DIGITS        = 3,
  parameter int SYNC_STAGES   = 2,
  parameter int REPEAT_CYCLES = 25000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                step_n,
  input  logic                load_n,
  input  logic                en,
  input  logic                dir,
  input  logic [WIDTH-1:0]    d,
  output logic [WIDTH-1:0]    count,
  output logic                tc,
  output logic [4*DIGITS-1:0] bcd,
  output logic                bcd_valid,
  output logic                busy
);

  localparam int              BW    = 4 * DIGITS;
  localparam int              CW    = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_COUNT);

  // Elaboration-time sanity checks on the parameter set.
  generate
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("bcd_step_counter: SYNC_STAGES must be at least 2");
    end
    if (MAX_COUNT > (2 ** WIDTH) - 1) begin : g_bad_max
      $error("bcd_step_counter: MAX_COUNT does not fit in WIDTH bits");
    end
    if (DIGITS < (WIDTH * 30103 + 99999) / 100000) begin : g_bad_digits
      $error("bcd_step_counter: DIGITS too small for WIDTH");
    end
    if (REPEAT_CYCLES < 1) begin : g_bad_repeat
      $error("bcd_step_counter: REPEAT_CYCLES must be positive");
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Button synchronisers; flops reset to 1 so the buttons read as released.
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] step_sync;
  logic [SYNC_STAGES-1:0] load_sync;
  logic                   step_prev;
  logic                   step_s;
  logic                   load_active;
  logic                   step_edge;
  logic                   step_pulse;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_sync <= '1;
      load_sync <= '1;
      step_prev <= 1'b1;
    end else begin
      step_sync <= {step_sync[SYNC_STAGES-2:0], step_n};
      load_sync <= {load_sync[SYNC_STAGES-2:0], load_n};
      step_prev <= step_s;
    end
  end

  assign step_s      = step_sync[SYNC_STAGES-1];
  assign load_active = ~load_sync[SYNC_STAGES-1];
  assign step_edge   = step_prev & ~step_s;

`ifdef STEP_REPEAT_EN
  // rep_cnt counts held cycles since the press edge; it is 0 on the edge
  // cycle itself, so the first repeat lands REPEAT_CYCLES after the edge.
  // Reloading 1 (not 0) after a repeat keeps the spacing at REPEAT_CYCLES.
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  logic [RW-1:0] rep_cnt;
  logic          rep_pulse;

  assign rep_pulse = ~step_s & (rep_cnt == RW'(REPEAT_CYCLES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt <= '0;
    end else if (step_s || load_active) begin
      rep_cnt <= '0;
    end else if (rep_pulse) begin
      rep_cnt <= RW'(1);
    end else begin
      rep_cnt <= rep_cnt + 1'b1;
    end
  end

  assign step_pulse = step_edge | rep_pulse;
`else
  assign step_pulse = step_edge;
`endif

  // ---------------------------------------------------------------------
  // Counter: load beats step, step wraps at the range ends with tc.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      tc    <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (load_active) begin
        count <= (d > MAX_C) ? MAX_C : d;
      end else if (step_pulse && en) begin
        if (dir) begin
          if (count == MAX_C) begin
            count <= '0;
            tc    <= 1'b1;
          end else begin
            count <= count + 1'b1;
          end
        end else begin
          if (count == '0) begin
            count <= MAX_C;
            tc    <= 1'b1;
          end else begin
            count <= count - 1'b1;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Binary-to-BCD converter.
  // count_q trails count by one clock, so "changed" is high exactly in the
  // cycle after a count update; any state reacts to it by (re)capturing.
  // ---------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    scratch;
  logic [BW-1:0]    adj;
  logic [CW-1:0]    bit_cnt;
  logic             changed;
  logic             capture;
  logic             shift_en;
  logic             publish;

  assign changed = (count != count_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    shift_en  = 1'b0;
    publish   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (changed) begin
          capture   = 1'b1;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // A new count aborts the running conversion and restarts it.
        if (changed) begin
          capture = 1'b1;
        end else begin
          shift_en = 1'b1;
          if (bit_cnt == CW'(WIDTH - 1)) begin
            state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        // The finished result is published even if count just moved again.
        publish = 1'b1;
        if (changed) begin
          capture   = 1'b1;
          state_nxt = ST_SHIFT;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Add 3 to every digit >= 5 so the following left shift carries into
  // the next decimal digit correctly.
  always_comb begin
    adj = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      shreg     <= '0;
      scratch   <= '0;
      bit_cnt   <= '0;
      bcd       <= '0;
      bcd_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      count_q   <= count;
      bcd_valid <= publish;
      if (publish) begin
        bcd  <= scratch;
        busy <= 1'b0;
      end
      if (capture) begin
        shreg   <= count;
        scratch <= '0;
        bit_cnt <= '0;
        busy    <= 1'b1;
      end else if (shift_en) begin
        shreg   <= shreg << 1;
        scratch <= (adj << 1) | BW'(shreg[WIDTH-1]);
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bcd_step_counter.sv
// tb/tb_bcd_step_counter.sv - self-checking bench for bcd_step_counter
//
// Purpose: drives directed button/load sequences and checks every cycle
// against a timing-rule model plus hand-computed literal expectations.
// Ports: none (top-level bench).

module tb_bcd_step_counter;

  localparam int W    = 8;
  localparam int MAXC = 199;
  localparam int DG   = 3;
  localparam int SS   = 2;
  localparam int RC   = 10;

`ifdef STEP_REPEAT_EN
  localparam int REP_INC = 4;
`else
  localparam int REP_INC = 1;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            step_n;
  logic            load_n;
  logic            en;
  logic            dir;
  logic [W-1:0]    d;
  logic [W-1:0]    count;
  logic            tc;
  logic [4*DG-1:0] bcd;
  logic            bcd_valid;
  logic            busy;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_on = 1'b0;

  bcd_step_counter #(
    .WIDTH        (W),
    .MAX_COUNT    (MAXC),
    .DIGITS       (DG),
    .SYNC_STAGES  (SS),
    .REPEAT_CYCLES(RC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .step_n   (step_n),
    .load_n   (load_n),
    .en       (en),
    .dir      (dir),
    .d        (d),
    .count    (count),
    .tc       (tc),
    .bcd      (bcd),
    .bcd_valid(bcd_valid),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // ---------------------------------------------------------------------
  // Model: raw button samples take effect SS edges later; a step is a
  // released->pressed transition of that delayed view. A conversion of the
  // value set at edge E is published at edge E+W+2 unless count moved again
  // at any edge E+1..E+W. busy is high from one edge after the latest change
  // through edge (latest change)+W+1.
  // ---------------------------------------------------------------------
  int          cyc;
  int          m_count;
  bit          m_tc;
  bit          m_valid;
  bit          m_busy;
  logic [11:0] m_bcd;
  int          last_chg;
  int          last_val;
  bit          have_chg;
  int          lc_prev;
  int          lv_prev;
  bit          have_prev;
  logic        hs[0:SS+1];
  logic        hl[0:SS+1];
`ifdef STEP_REPEAT_EN
  int          low_for;
`endif

  task automatic model_reset();
    cyc       = 0;
    m_count   = 0;
    m_tc      = 1'b0;
    m_valid   = 1'b0;
    m_busy    = 1'b0;
    m_bcd     = 12'h000;
    last_chg  = 0;
    last_val  = 0;
    have_chg  = 1'b0;
    lc_prev   = 0;
    lv_prev   = 0;
    have_prev = 1'b0;
    for (int k = 0; k <= SS + 1; k++) begin
      hs[k] = 1'b1;
      hl[k] = 1'b1;
    end
`ifdef STEP_REPEAT_EN
    low_for = 0;
`endif
  endtask

  task automatic model_step();
    int old;
    bit pulse;
    cyc++;
    for (int k = SS + 1; k > 0; k--) begin
      hs[k] = hs[k-1];
      hl[k] = hl[k-1];
    end
    hs[0] = step_n;
    hl[0] = load_n;
    pulse = hs[SS+1] && !hs[SS];
`ifdef STEP_REPEAT_EN
    if (!hs[SS] && low_for > 0 && (low_for % RC) == 0) pulse = 1'b1;
    if (!hs[SS] && hl[SS]) low_for++;
    else low_for = 0;
`endif
    old  = m_count;
    m_tc = 1'b0;
    if (!hl[SS]) begin
      m_count = (int'(d) > MAXC) ? MAXC : int'(d);
    end else if (pulse && en) begin
      if (dir) begin
        if (old == MAXC) begin m_count = 0; m_tc = 1'b1; end
        else m_count = old + 1;
      end else begin
        if (old == 0) begin m_count = MAXC; m_tc = 1'b1; end
        else m_count = old - 1;
      end
    end
    m_valid = 1'b0;
    if (have_prev && lc_prev == cyc - W - 2) begin
      m_valid = 1'b1;
      m_bcd   = to_bcd(lv_prev);
    end
    m_busy    = have_chg && (cyc <= last_chg + W + 1);
    lc_prev   = last_chg;
    lv_prev   = last_val;
    have_prev = have_chg;
    if (m_count != old) begin
      last_chg = cyc;
      last_val = m_count;
      have_chg = 1'b1;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_on) begin
        check($sformatf("count@%0d", cyc), count, m_count);
        check($sformatf("tc@%0d", cyc), tc, m_tc);
        check($sformatf("bcd@%0d", cyc), bcd, m_bcd);
        check($sformatf("bcd_valid@%0d", cyc), bcd_valid, m_valid);
        check($sformatf("busy@%0d", cyc), busy, m_busy);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Directed stimulus with literal expectations.
  // ---------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-clock load press; returns just after the edge that applies it.
  task automatic load_pulse(input logic [W-1:0] v);
    d      = v;
    load_n = 1'b0;
    tick(1);
    load_n = 1'b1;
    tick(2);
  endtask

  initial begin
    rst_n  = 1'b0;
    step_n = 1'b1;
    load_n = 1'b1;
    en     = 1'b1;
    dir    = 1'b1;
    d      = '0;
    tick(3);
    check("reset_count", count, 0);
    check("reset_tc", tc, 0);
    check("reset_bcd", bcd, 12'h000);
    check("reset_valid", bcd_valid, 0);
    check("reset_busy", busy, 0);
    rst_n  = 1'b1;
    cmp_on = 1'b1;
    tick(2);

    // Load 37, then asynchronous reset in the middle of its conversion.
    load_pulse(8'd37);
    check("load37_count", count, 37);
    tick(4);
    check("load37_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_count", count, 0);
    check("async_rst_bcd", bcd, 12'h000);
    check("async_rst_busy", busy, 0);
    check("async_rst_valid", bcd_valid, 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // Load 123 held for four clocks: applied on the 3rd edge, bcd 10 later.
    d      = 8'd123;
    load_n = 1'b0;
    tick(2);
    check("load123_edge2", count, 0);
    tick(1);
    check("load123_edge3", count, 123);
    tick(1);
    load_n = 1'b1;
    tick(8);
    check("load123_valid_early", bcd_valid, 0);
    tick(1);
    check("load123_valid", bcd_valid, 1);
    check("load123_bcd", bcd, 12'h123);
    tick(1);
    check("load123_valid_once", bcd_valid, 0);

    // Up-wrap from 199.
    load_pulse(8'd199);
    tick(12);
    step_n = 1'b0;
    tick(2);
    check("upwrap_edge2", count, 199);
    tick(1);
    check("upwrap_count", count, 0);
    check("upwrap_tc", tc, 1);
    step_n = 1'b1;
    tick(1);
    check("upwrap_tc_end", tc, 0);
    tick(9);
    check("upwrap_valid", bcd_valid, 1);
    check("upwrap_bcd", bcd, 12'h000);

    // Down-wrap from 0.
    dir    = 1'b0;
    step_n = 1'b0;
    tick(3);
    check("downwrap_count", count, 199);
    check("downwrap_tc", tc, 1);
    step_n = 1'b1;
    tick(1);
    check("downwrap_tc_end", tc, 0);
    tick(9);
    check("downwrap_valid", bcd_valid, 1);
    check("downwrap_bcd", bcd, 12'h199);
    dir = 1'b1;

    // Saturating load, load beating a simultaneous step, disabled step.
    load_pulse(8'd5);
    tick(12);
    load_pulse(8'd250);
    check("sat_load", count, 199);
    tick(12);
    d      = 8'd42;
    load_n = 1'b0;
    step_n = 1'b0;
    tick(1);
    load_n = 1'b1;
    tick(2);
    check("load_wins", count, 42);
    tick(3);
    step_n = 1'b1;
    check("load_wins_hold", count, 42);
    tick(12);
    en     = 1'b0;
    step_n = 1'b0;
    tick(4);
    step_n = 1'b1;
    tick(2);
    check("en_off", count, 42);
    en = 1'b1;
    tick(2);

    // Two steps four clocks apart from 98: one result, busy throughout.
    load_pulse(8'd98);
    tick(12);
    step_n = 1'b0;
    tick(2);
    step_n = 1'b1;
    tick(2);
    check("restart_first", count, 99);
    step_n = 1'b0;
    tick(2);
    step_n = 1'b1;
    tick(1);
    check("restart_second", count, 100);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("restart_busy_%0d", i), busy, 1);
      check($sformatf("restart_novalid_%0d", i), bcd_valid, 0);
      tick(1);
    end
    check("restart_valid", bcd_valid, 1);
    check("restart_bcd", bcd, 12'h100);
    check("restart_idle", busy, 0);

    // Step held for 35 clocks.
    load_pulse(8'd10);
    tick(12);
    step_n = 1'b0;
    tick(35);
    step_n = 1'b1;
    tick(5);
    check("held_step", count, 10 + REP_INC);
    tick(15);

    cmp_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
